// File: rtl/wb_regfile.sv
// wb_regfile: register file with per-register pending scoreboard for an
// in-order issue stage feeding a one-stage ALU.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   issue_valid_i       decoder presents an instruction this cycle
//   issue_wb_wr_i       presented instruction writes a destination register
//   issue_reg_dst_i     destination of the presented instruction
//   rd_en_1_i/2_i       source 1/2 used by the presented instruction
//   rd_addr_1_i/2_i     source 1/2 register address
//   rd_data_1_o/2_o     source operand values (with same-cycle writeback bypass)
//   stall_o             presented instruction is not accepted this cycle
//   wb_wr_i             ALU writeback enable
//   reg_dst_i           ALU writeback address
//   dst_i               ALU result
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 16,
    localparam int unsigned AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    input  logic              issue_wb_wr_i,
    input  logic [AW-1:0]     issue_reg_dst_i,
    input  logic              rd_en_1_i,
    input  logic              rd_en_2_i,
    input  logic [AW-1:0]     rd_addr_1_i,
    input  logic [AW-1:0]     rd_addr_2_i,
    output logic [DATA_W-1:0] rd_data_1_o,
    output logic [DATA_W-1:0] rd_data_2_o,
    output logic              stall_o,
    input  logic              wb_wr_i,
    input  logic [AW-1:0]     reg_dst_i,
    input  logic [DATA_W-1:0] dst_i
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pending;

    logic              w_wb_valid;
    logic              w_byp_1;
    logic              w_byp_2;
    logic              w_hazard_1;
    logic              w_hazard_2;
    logic              w_issue_set;
    logic [NREG-1:0]   w_pending_d;

    // Writes to r0 are dropped entirely, so r0 never becomes pending either.
    assign w_wb_valid = wb_wr_i && (reg_dst_i != '0);

    assign w_byp_1 = w_wb_valid && (reg_dst_i == rd_addr_1_i);
    assign w_byp_2 = w_wb_valid && (reg_dst_i == rd_addr_2_i);

    always_comb begin
        rd_data_1_o = r_regs[rd_addr_1_i];
        if (rd_addr_1_i == '0) begin
            rd_data_1_o = '0;
        end else if (w_byp_1) begin
            rd_data_1_o = dst_i;
        end
    end

    always_comb begin
        rd_data_2_o = r_regs[rd_addr_2_i];
        if (rd_addr_2_i == '0) begin
            rd_data_2_o = '0;
        end else if (w_byp_2) begin
            rd_data_2_o = dst_i;
        end
    end

    // A writeback arriving this cycle resolves the hazard through the bypass.
    assign w_hazard_1 = rd_en_1_i && (rd_addr_1_i != '0) && r_pending[rd_addr_1_i] && !w_byp_1;
    assign w_hazard_2 = rd_en_2_i && (rd_addr_2_i != '0) && r_pending[rd_addr_2_i] && !w_byp_2;

    assign stall_o = issue_valid_i && (w_hazard_1 || w_hazard_2);

    assign w_issue_set = issue_valid_i && !stall_o && issue_wb_wr_i && (issue_reg_dst_i != '0);

    // Set is applied after clear so a same-cycle collision leaves the bit at 1.
    always_comb begin
        w_pending_d = r_pending;
        for (int i = 0; i < int'(NREG); i++) begin
            if (w_wb_valid && (reg_dst_i == AW'(i))) begin
                w_pending_d[i] = 1'b0;
            end
            if (w_issue_set && (issue_reg_dst_i == AW'(i))) begin
                w_pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_pending <= w_pending_d;
            if (w_wb_valid) begin
                r_regs[reg_dst_i] <= dst_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid_i = 1'b0;
    logic          issue_wb_wr_i = 1'b0;
    logic [3:0]    issue_reg_dst_i = '0;
    logic          rd_en_1_i = 1'b0;
    logic          rd_en_2_i = 1'b0;
    logic [3:0]    rd_addr_1_i = '0;
    logic [3:0]    rd_addr_2_i = '0;
    logic [DW-1:0] rd_data_1_o;
    logic [DW-1:0] rd_data_2_o;
    logic          stall_o;
    logic          wb_wr_i = 1'b0;
    logic [3:0]    reg_dst_i = '0;
    logic [DW-1:0] dst_i = '0;

    wb_regfile #(.DATA_W(DW), .NREG(NR)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid_i   (issue_valid_i),
        .issue_wb_wr_i   (issue_wb_wr_i),
        .issue_reg_dst_i (issue_reg_dst_i),
        .rd_en_1_i       (rd_en_1_i),
        .rd_en_2_i       (rd_en_2_i),
        .rd_addr_1_i     (rd_addr_1_i),
        .rd_addr_2_i     (rd_addr_2_i),
        .rd_data_1_o     (rd_data_1_o),
        .rd_data_2_o     (rd_data_2_o),
        .stall_o         (stall_o),
        .wb_wr_i         (wb_wr_i),
        .reg_dst_i       (reg_dst_i),
        .dst_i           (dst_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          stall;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference state: architectural register values and the set of
    // registers whose result is still outstanding.
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] m_read(logic [3:0] a, logic wb, logic [3:0] wd,
                                             logic [DW-1:0] wdat);
        if (a == 0) return '0;
        if (wb && wd == a) return wdat;
        return m_regs[a];
    endfunction

    function automatic bit m_hazard(logic en, logic [3:0] a, logic wb, logic [3:0] wd);
        return en && a != 0 && m_pend[a] && !(wb && wd == a);
    endfunction

    // Monitor: one expected entry per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total += 3;
            if (stall_o !== mon_e.stall) begin
                bad++;
                $display("FAIL stall tag=%0d got=%b want=%b", mon_e.tag, stall_o, mon_e.stall);
            end
            if (rd_data_1_o !== mon_e.d1) begin
                bad++;
                $display("FAIL rd_data_1 tag=%0d got=%h want=%h", mon_e.tag, rd_data_1_o,
                         mon_e.d1);
            end
            if (rd_data_2_o !== mon_e.d2) begin
                bad++;
                $display("FAIL rd_data_2 tag=%0d got=%h want=%h", mon_e.tag, rd_data_2_o,
                         mon_e.d2);
            end
        end
    end

    task automatic cyc(input logic iv, input logic iw, input logic [3:0] idst,
                       input logic e1, input logic [3:0] a1,
                       input logic e2, input logic [3:0] a2,
                       input logic wb, input logic [3:0] wd, input logic [DW-1:0] wdat,
                       input int tag);
        exp_t e;
        bit   st;
        issue_valid_i   = iv;
        issue_wb_wr_i   = iw;
        issue_reg_dst_i = idst;
        rd_en_1_i       = e1;
        rd_addr_1_i     = a1;
        rd_en_2_i       = e2;
        rd_addr_2_i     = a2;
        wb_wr_i         = wb;
        reg_dst_i       = wd;
        dst_i           = wdat;
        st      = iv && (m_hazard(e1, a1, wb, wd) || m_hazard(e2, a2, wb, wd));
        e.stall = st;
        e.d1    = m_read(a1, wb, wd, wdat);
        e.d2    = m_read(a2, wb, wd, wdat);
        e.tag   = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (wb && wd != 0) begin
            m_regs[wd] = wdat;
            m_pend[wd] = 1'b0;
        end
        if (iv && !st && iw && idst != 0) m_pend[idst] = 1'b1;
    endtask

    // Reset cycle with junk traffic that must be ignored.
    task automatic do_reset();
        rst             = 1'b1;
        issue_valid_i   = 1'b1;
        issue_wb_wr_i   = 1'b1;
        issue_reg_dst_i = 4'd6;
        wb_wr_i         = 1'b1;
        reg_dst_i       = 4'd6;
        dst_i           = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_wr_i = 1'b0;
        issue_valid_i = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Post-reset: all reads zero, no stall with both sources enabled.
        for (int a = 0; a < NR; a++) begin
            cyc(1, 0, 0, 1, 4'(a), 1, 4'(NR - 1 - a), 0, 0, 0, 100 + a);
        end

        // Write then read, with same-cycle bypass.
        cyc(0, 0, 0, 0, 4'd3, 0, 4'd3, 1, 4'd3, 32'h0000_00A5, 200);
        cyc(0, 0, 0, 0, 4'd3, 0, 4'd0, 0, 0, 0, 201);

        // RAW stall then writeback resolves it via bypass.
        cyc(1, 1, 4'd5, 0, 0, 0, 0, 0, 0, 0, 300);
        cyc(1, 0, 0, 1, 4'd5, 0, 0, 0, 0, 0, 301);
        cyc(1, 0, 0, 1, 4'd5, 0, 0, 1, 4'd5, 32'h1234, 302);
        cyc(1, 0, 0, 0, 0, 1, 4'd5, 0, 0, 0, 303);

        // r0 rules.
        cyc(0, 0, 0, 1, 4'd0, 1, 4'd0, 1, 4'd0, 32'hFFFF_FFFF, 400);
        cyc(1, 1, 4'd0, 1, 4'd0, 1, 4'd0, 0, 0, 0, 401);
        cyc(1, 0, 0, 1, 4'd0, 1, 4'd0, 0, 0, 0, 402);

        // Set/clear collision on r7.
        cyc(1, 1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 500);
        cyc(1, 1, 4'd7, 0, 0, 0, 0, 1, 4'd7, 32'h77, 501);
        cyc(1, 0, 0, 0, 0, 1, 4'd7, 0, 0, 0, 502);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4'd7, 32'h7777, 503);
        cyc(1, 0, 0, 1, 4'd7, 1, 4'd7, 0, 0, 0, 504);

        // Reset mid-flight discards pending state.
        cyc(1, 1, 4'd9, 0, 0, 0, 0, 0, 0, 0, 600);
        do_reset();
        cyc(1, 0, 0, 1, 4'd9, 1, 4'd7, 0, 0, 0, 601);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4'd9, 32'h99, 602);
        cyc(1, 0, 0, 1, 4'd9, 0, 0, 0, 0, 0, 603);

        // Randomized traffic; narrow address range half the time to force hazards.
        for (int n = 0; n < 3000; n++) begin
            int unsigned hi;
            hi = ($urandom_range(0, 1) == 0) ? 3 : 15;
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, hi)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, hi)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, hi)),
                1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, hi)), $urandom(),
                1000 + n);
        end

        issue_valid_i = 1'b0;
        wb_wr_i = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set register width; it matches imm_t.
REQ-002 Parameter NREG, default 16, SHALL set the register count; the address width is clog2(NREG) and matches reg_t.
REQ-003 clk  in  1  single clock; all state SHALL update on the posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 issue_valid_i  in  1  decoder presents an instruction this cycle.
REQ-006 issue_wb_wr_i  in  1  the presented instruction writes a destination register.
REQ-007 issue_reg_dst_i  in  reg_t  destination of the presented instruction.
REQ-008 rd_en_1_i / rd_en_2_i  in  1 each  source 1/2 is used by the presented instruction.
REQ-009 rd_addr_1_i / rd_addr_2_i  in  reg_t each  source 1/2 register address.
REQ-010 rd_data_1_o / rd_data_2_o  out  DATA_W each  source operand values, fed to the ALU src_1/src_2.
REQ-011 stall_o  out  1  presented instruction SHALL NOT be accepted this cycle.
REQ-012 wb_wr_i  in  1  ALU writeback enable (ALU wb_wr_o).
REQ-013 reg_dst_i  in  reg_t  ALU writeback address (ALU reg_dst_o).
REQ-014 dst_i  in  DATA_W  ALU result (ALU dst_o).

Function
REQ-015 Register 0 SHALL read as 0 always; writes to it SHALL be discarded and SHALL NOT set pending.
REQ-016 Write: when wb_wr_i=1 and reg_dst_i!=0, regs[reg_dst_i] SHALL take dst_i at the next posedge.
REQ-017 Read: rd_data_n_o SHALL be combinational from rd_addr_n_i, independent of rd_en_n_i.
REQ-018 Bypass: when wb_wr_i=1, reg_dst_i==rd_addr_n_i, and the address is !=0, rd_data_n_o SHALL equal dst_i in the same cycle.
REQ-019 Scoreboard: each register SHALL have one pending bit.
REQ-020 A pending bit SHALL be set at the posedge after an accepted issue (issue_valid_i=1, stall_o=0) with issue_wb_wr_i=1.
REQ-021 A pending bit SHALL be cleared at the posedge after wb_wr_i=1 to that address.
REQ-022 When a set and a clear hit the same register in the same cycle, the set SHALL win and the bit SHALL end at 1.
REQ-023 Hazard n SHALL be true when rd_en_n_i=1, rd_addr_n_i!=0, pending[rd_addr_n_i]=1, and no writeback to that address is present this cycle.
REQ-024 stall_o SHALL equal issue_valid_i AND (hazard 1 OR hazard 2); it is combinational with zero-cycle latency.
REQ-025 stall_o SHALL be 0 whenever issue_valid_i=0.
REQ-026 A stalled instruction SHALL NOT modify the scoreboard.
REQ-027 Writeback latency: the result SHALL be visible at the bypass in the cycle it is presented, and from the array on every cycle after.
REQ-028 A writeback to a non-pending register SHALL still update the array; the pending bit stays 0.
REQ-029 Back-to-back issues to the same destination SHALL be allowed without stall, because the block is in-order and the ALU has one stage.

Reset
REQ-030 While rst=1 at a posedge, all registers SHALL clear to 0 and all pending bits SHALL clear to 0.
REQ-031 During rst=1, concurrent writeback and issue SHALL be ignored.
REQ-032 Immediately after reset, rd_data_*_o SHALL read 0 for all addresses and stall_o SHALL be 0.
REQ-033 Asserting reset mid-operation SHALL discard in-flight pending state; a later wb_wr_i to a formerly pending register SHALL only write the array.

Verification
REQ-034 Reset check: assert rst, then read all NREG addresses -> every read is 0x0; issue_valid_i=1 with both sources enabled -> stall_o=0.
REQ-035 Write then read: wb_wr_i=1, reg_dst_i=3, dst_i=0x0000_00A5 in one cycle; read r3 next cycle -> 0xA5. Bypass: the same cycle read of r3 -> 0xA5.
REQ-036 RAW stall: issue dst=5 (accepted); next cycle issue with rd_en_1=1, addr=5, and wb_wr_i=0 -> stall_o=1. Then wb_wr_i=1, reg_dst_i=5, dst_i=0x1234 -> stall_o=0 and rd_data_1_o=0x1234 in that cycle.
REQ-037 r0 rules: wb_wr_i=1, reg_dst_i=0, dst_i=0xFFFF_FFFF -> r0 still reads 0. Issue dst=0, then source r0 -> no stall.
REQ-038 Set/clear collision: issue dst=7 in cycle N; in cycle N+1, wb_wr_i=1 to r7 plus another accepted issue dst=7 -> pending[7]=1. In cycle N+2, a source read of r7 with no writeback -> stall_o=1.
REQ-039 Reset mid-flight: issue dst=9, then rst=1 for one cycle, then a source read of r9 -> stall_o=0 and data 0.
